uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver with 8N1-style framing: one start bit, DATA_WIDTH data bits sent LSB first, one stop bit, no parity. It takes the raw line from the board pin, synchronizes it, samples each bit at its centre, and presents each received word on a valid/ready handshake with a one-entry holding register. It is the receive end of the team's UART link and uses the same baud arithmetic and `ena` gating as the transmitter.

## Interface
- DATA_WIDTH, 8: bits per frame.
- BAUD_RATE, 115_200: line rate in bits per second.
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- Derived constants:
  - PULSE_WIDTH = CLK_FREQ/BAUD_RATE (integer division), which is 434 at the defaults.
  - HALF_PULSE_WIDTH = PULSE_WIDTH/2, which is 217 at the defaults.
  - PULSE_WIDTH must be at least 4.
- clk  in  1  the only clock.
- reset  in  1  synchronous, active-high reset. One clock domain; reset is synchronous and active-high.
- ena  in  1  clock enable. While low, all registers hold, including the synchronizer.
- rx_signal  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_WIDTH  received word; stable while rx_valid is high.
- rx_valid  out  1  word available; held until accepted.
- rx_ready  in  1  consumer accepts the word.
- rx_frame_error  out  1  one-cycle pulse: the stop bit was sampled low.
- rx_overrun  out  1  one-cycle pulse: a new word was dropped because the holding register was full.
- rx_busy  out  1  high whenever the state is not IDLE.

## Operation
- Synchronizer: two flops, sync1 then sync2. rx_s = sync2. Both flops reset to 1. All state decisions use rx_s.
- Counters:
  - CLK_CNT is $clog2(PULSE_WIDTH)+1 bits wide.
  - BIT_CNT is $clog2(DATA_WIDTH) bits wide.
  - SHIFT is DATA_WIDTH bits wide.
- States:
  - IDLE: when rx_s == 0, go to START and load CLK_CNT with HALF_PULSE_WIDTH-1.
  - START: if CLK_CNT > 0, decrement. At 0:
    - rx_s == 0: go to DATA, load CLK_CNT with PULSE_WIDTH-1, set BIT_CNT to 0.
    - rx_s == 1: false start; return to IDLE. No flags.
  - DATA: if CLK_CNT > 0, decrement. At 0:
    - write SHIFT[BIT_CNT] with rx_s and reload PULSE_WIDTH-1.
    - if BIT_CNT == DATA_WIDTH-1, go to STOP; otherwise increment BIT_CNT.
  - STOP: if CLK_CNT > 0, decrement. At 0:
    - rx_s == 1: deliver SHIFT (see handshake) and go to IDLE.
    - rx_s == 0: pulse rx_frame_error, discard SHIFT, go to BREAK.
  - BREAK: wait for rx_s == 1, then go to IDLE. A low line is never re-detected as a start bit in this state.
  - Illegal state encoding: go to IDLE.
- Handshake and delivery:
  - An accept occurs on any cycle with rx_valid && rx_ready; rx_valid then clears on the next cycle.
  - On delivery with rx_valid low, or with rx_valid high and rx_ready high in the same cycle: rx_data <= SHIFT and rx_valid <= 1. No overrun.
  - On delivery with rx_valid high and rx_ready low: rx_data keeps the old word, the new word is dropped, and rx_overrun pulses for one cycle.
- Reset values: rx_data = 0, rx_valid = 0, rx_frame_error = 0, rx_overrun = 0, rx_busy = 0, state = IDLE, all counters 0.
- Reset mid-frame: the partial word is lost, no flags are raised, and reception resumes at the next falling edge after the line is high.
- ena low: counters and state freeze and pulses are not generated. Timing stretches by the number of cycles ena was low. Accept is also gated by ena.

## Timing
- Let E0 be the clk edge at which sync1 first samples rx_signal low. Count edges with ena continuously high:
  - Start check at edge E0 + HALF_PULSE_WIDTH + 2.
  - Data bit k sampled at edge E0 + HALF_PULSE_WIDTH + 2 + (k+1)·PULSE_WIDTH.
  - Stop bit sampled at edge E0 + HALF_PULSE_WIDTH + 2 + (DATA_WIDTH+1)·PULSE_WIDTH. rx_valid is high after this edge: 4125 edges at the defaults.
- rx_frame_error and rx_overrun are high for exactly one cycle, appearing after the stop-sample edge.
- Back-to-back frames: IDLE is entered at the stop-bit centre, so a start edge half a bit later is caught.

## Test plan
Use fast parameters unless stated: CLK_FREQ = 1_000_000, BAUD_RATE = 100_000, giving PULSE_WIDTH = 10 and HALF_PULSE_WIDTH = 5.
- Reset with the line idle, then send 0xA5 at 10 clocks per bit with rx_ready low -> rx_valid rises 5+2+90 = 97 edges after E0 and rx_data = 0xA5. Raise rx_ready -> rx_valid low the next cycle.
- Drive rx_signal low for 3 clocks only -> rx_busy pulses, no rx_valid, no flags, state back in IDLE.
- Send 0x3C with the stop bit low, hold the line low for 200 clocks, then release it high -> exactly one rx_frame_error pulse, no rx_valid, no new frame started during the low period. A following 0x55 is received correctly.
- Send 0x00 then 0xFF back-to-back with rx_ready low -> rx_data = 0x00, one rx_overrun pulse at the second stop sample. Repeat with rx_ready pulsed high exactly on the second stop-sample cycle -> rx_data = 0xFF, no overrun.
- Assert reset during data bit 4 of a frame -> all outputs return to their reset values next cycle. The next full frame, 0x81, is received intact.
- Send 0xC3 while toggling ena low for 7 cycles in every 20 -> rx_data = 0xC3 and no errors. Then send 0x5A at the defaults (PULSE_WIDTH = 434) -> rx_valid appears after 4125 edges.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: one start bit, DATA_WIDTH data bits LSB first, one stop bit.
// The line is double-synchronized and each bit is sampled at its centre.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  rx_signal,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_frame_error,
  output logic                  rx_overrun,
  output logic                  rx_busy
);

  // PULSE_WIDTH must be at least 4 for the half-bit load to be meaningful.
  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
  localparam int BIT_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  sync1;
  logic                  sync2;
  logic                  rx_s;
  logic [CNT_W-1:0]      clk_cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_next;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  deliver;
  logic                  frame_err;

  assign rx_s = sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (ena) begin
      sync1   <= rx_signal;
      sync2   <= sync1;
      state   <= state_next;
      clk_cnt <= cnt_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = clk_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    deliver    = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (clk_cnt != '0) begin
          cnt_next = clk_cnt - 1'b1;
        end else if (!rx_s) begin
          state_next = DATA;
          cnt_next   = FULL_LOAD;
          bit_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (clk_cnt != '0) begin
          cnt_next = clk_cnt - 1'b1;
        end else begin
          shift_next[bit_cnt] = rx_s;
          cnt_next            = FULL_LOAD;
          if (bit_cnt == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (clk_cnt != '0) begin
          cnt_next = clk_cnt - 1'b1;
        end else if (rx_s) begin
          deliver    = 1'b1;
          state_next = IDLE;
        end else begin
          frame_err  = 1'b1;
          state_next = BREAK;
        end
      end
      // A held-low line must be released before a new start bit is accepted.
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    rx_busy = (state != IDLE);
  end

  // Pulses are cleared while stalled so they never stretch past one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_frame_error <= 1'b0;
      rx_overrun     <= 1'b0;
    end else if (ena) begin
      rx_frame_error <= frame_err;
      rx_overrun     <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end else begin
      rx_frame_error <= 1'b0;
      rx_overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: a fast instance (10 clocks per bit) for most
// scenarios and a default-parameter instance for the full-rate latency.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       rx_signal;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_error;
  logic       rx_overrun;
  logic       rx_busy;

  logic       rx_signal_s;
  logic       rx_ready_s;
  logic [7:0] rx_data_s;
  logic       rx_valid_s;
  logic       fe_s;
  logic       ov_s;
  logic       busy_s;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;

  int valid_rises    = 0;
  int valid_rise_cyc = 0;
  int slow_rise_cyc  = 0;
  int fe_cnt         = 0;
  int ov_cnt         = 0;
  int ov_cyc         = 0;
  int busy_cycles    = 0;
  logic valid_q      = 1'b0;
  logic valid_s_q    = 1'b0;

  int last_start_cyc = 0;
  int frame_no       = 0;
  bit gate_on        = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000)) dut (
    .clk(clk), .reset(reset), .ena(ena), .rx_signal(rx_signal),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_error(rx_frame_error), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  uart_rx dut_slow (
    .clk(clk), .reset(reset), .ena(ena), .rx_signal(rx_signal_s),
    .rx_data(rx_data_s), .rx_valid(rx_valid_s), .rx_ready(rx_ready_s),
    .rx_frame_error(fe_s), .rx_overrun(ov_s), .rx_busy(busy_s)
  );

  // Event monitor sampled mid-cycle, so each one-cycle pulse is seen once.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && valid_q !== 1'b1) begin
      valid_rises++;
      valid_rise_cyc = cyc;
    end
    valid_q = rx_valid;
    if (rx_valid_s === 1'b1 && valid_s_q !== 1'b1) slow_rise_cyc = cyc;
    valid_s_q = rx_valid_s;
    if (rx_frame_error === 1'b1) fe_cnt++;
    if (rx_overrun === 1'b1) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (rx_busy === 1'b1) busy_cycles++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Wait n enabled clock edges, returning 1 time unit after the last one.
  task automatic hold(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      #1;
      if (ena) c++;
    end
  endtask

  task automatic set_line(input logic v, input bit slow);
    if (slow) rx_signal_s = v;
    else rx_signal = v;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_val, input int pw, input bit slow);
    set_line(1'b0, slow);
    last_start_cyc = cyc;
    frame_no++;
    hold(pw);
    for (int i = 0; i < 8; i++) begin
      set_line(d[i], slow);
      hold(pw);
    end
    set_line(stop_val, slow);
    hold(pw);
  endtask

  task automatic test_reset();
    rx_signal   = 1'b1;
    rx_signal_s = 1'b1;
    rx_ready    = 1'b0;
    rx_ready_s  = 1'b0;
    ena         = 1'b1;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    assert_cnt++; if (rx_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid); end
    assert_cnt++; if (rx_data !== 8'h00) begin fail_cnt++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data); end
    assert_cnt++; if (rx_frame_error !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_fe: got %b expected 0", rx_frame_error); end
    assert_cnt++; if (rx_overrun !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_ov: got %b expected 0", rx_overrun); end
    assert_cnt++; if (rx_busy !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_busy: got %b expected 0", rx_busy); end
    assert_cnt++; if (rx_valid_s !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_valid_slow: got %b expected 0", rx_valid_s); end
    reset = 1'b0;
    hold(3);
  endtask

  task automatic test_basic();
    int fe0 = fe_cnt;
    send_byte(8'hA5, 1'b1, 10, 1'b0);
    hold(5);
    assert_cnt++; if (rx_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL basic_valid: got %b expected 1", rx_valid); end
    assert_cnt++; if (rx_data !== 8'hA5) begin fail_cnt++; $display("[TB] FAIL basic_data: got %h expected a5", rx_data); end
    assert_cnt++; if (valid_rise_cyc - last_start_cyc != 98) begin fail_cnt++; $display("[TB] FAIL basic_latency: got %0d expected 98", valid_rise_cyc - last_start_cyc); end
    assert_cnt++; if (fe_cnt != fe0) begin fail_cnt++; $display("[TB] FAIL basic_fe: got %0d expected %0d", fe_cnt, fe0); end
    rx_ready = 1'b1;
    hold(1);
    rx_ready = 1'b0;
    assert_cnt++; if (rx_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL basic_accept: got %b expected 0", rx_valid); end
  endtask

  task automatic test_false_start();
    int r0 = valid_rises;
    int f0 = fe_cnt;
    int o0 = ov_cnt;
    int b0 = busy_cycles;
    rx_signal = 1'b0;
    hold(3);
    rx_signal = 1'b1;
    hold(30);
    assert_cnt++; if (busy_cycles <= b0) begin fail_cnt++; $display("[TB] FAIL false_busy_pulse: got %0d busy cycles expected >0", busy_cycles - b0); end
    assert_cnt++; if (valid_rises != r0) begin fail_cnt++; $display("[TB] FAIL false_valid: got %0d words expected %0d", valid_rises, r0); end
    assert_cnt++; if (fe_cnt != f0) begin fail_cnt++; $display("[TB] FAIL false_fe: got %0d expected %0d", fe_cnt, f0); end
    assert_cnt++; if (ov_cnt != o0) begin fail_cnt++; $display("[TB] FAIL false_ov: got %0d expected %0d", ov_cnt, o0); end
    assert_cnt++; if (rx_busy !== 1'b0) begin fail_cnt++; $display("[TB] FAIL false_idle: got %b expected 0", rx_busy); end
  endtask

  task automatic test_frame_error();
    int r0 = valid_rises;
    int f0 = fe_cnt;
    send_byte(8'h3C, 1'b0, 10, 1'b0);
    hold(200);
    assert_cnt++; if (rx_busy !== 1'b1) begin fail_cnt++; $display("[TB] FAIL break_busy: got %b expected 1", rx_busy); end
    assert_cnt++; if (fe_cnt != f0 + 1) begin fail_cnt++; $display("[TB] FAIL break_fe_low: got %0d expected %0d", fe_cnt, f0 + 1); end
    rx_signal = 1'b1;
    hold(5);
    assert_cnt++; if (rx_busy !== 1'b0) begin fail_cnt++; $display("[TB] FAIL break_release: got %b expected 0", rx_busy); end
    assert_cnt++; if (fe_cnt != f0 + 1) begin fail_cnt++; $display("[TB] FAIL break_fe_count: got %0d expected %0d", fe_cnt, f0 + 1); end
    assert_cnt++; if (valid_rises != r0) begin fail_cnt++; $display("[TB] FAIL break_no_word: got %0d expected %0d", valid_rises, r0); end
    send_byte(8'h55, 1'b1, 10, 1'b0);
    hold(5);
    assert_cnt++; if (rx_data !== 8'h55) begin fail_cnt++; $display("[TB] FAIL after_break_data: got %h expected 55", rx_data); end
    assert_cnt++; if (rx_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL after_break_valid: got %b expected 1", rx_valid); end
    rx_ready = 1'b1;
    hold(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int o0 = ov_cnt;
    int o1;
    int f0;
    send_byte(8'h00, 1'b1, 10, 1'b0);
    send_byte(8'hFF, 1'b1, 10, 1'b0);
    hold(5);
    assert_cnt++; if (rx_data !== 8'h00) begin fail_cnt++; $display("[TB] FAIL b2b_keep_data: got %h expected 00", rx_data); end
    assert_cnt++; if (rx_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL b2b_valid: got %b expected 1", rx_valid); end
    assert_cnt++; if (ov_cnt != o0 + 1) begin fail_cnt++; $display("[TB] FAIL b2b_overrun: got %0d expected %0d", ov_cnt, o0 + 1); end
    assert_cnt++; if (ov_cyc - last_start_cyc != 98) begin fail_cnt++; $display("[TB] FAIL b2b_ov_time: got %0d expected 98", ov_cyc - last_start_cyc); end
    rx_ready = 1'b1;
    hold(1);
    rx_ready = 1'b0;
    o1 = ov_cnt;
    f0 = frame_no;
    fork
      begin
        send_byte(8'h00, 1'b1, 10, 1'b0);
        send_byte(8'hFF, 1'b1, 10, 1'b0);
      end
      begin
        while (frame_no < f0 + 2) begin @(posedge clk); #1; end
        while (cyc < last_start_cyc + 97) begin @(posedge clk); #1; end
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
      end
    join
    hold(5);
    assert_cnt++; if (rx_data !== 8'hFF) begin fail_cnt++; $display("[TB] FAIL b2b_ready_data: got %h expected ff", rx_data); end
    assert_cnt++; if (rx_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL b2b_ready_valid: got %b expected 1", rx_valid); end
    assert_cnt++; if (ov_cnt != o1) begin fail_cnt++; $display("[TB] FAIL b2b_ready_no_ov: got %0d expected %0d", ov_cnt, o1); end
  endtask

  task automatic test_reset_mid_frame();
    int f0 = frame_no;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    int r0;
    fork
      send_byte(8'hF0, 1'b1, 10, 1'b0);
      begin
        while (frame_no < f0 + 1) begin @(posedge clk); #1; end
        while (cyc < last_start_cyc + 55) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        assert_cnt++; if (rx_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL midreset_valid: got %b expected 0", rx_valid); end
        assert_cnt++; if (rx_data !== 8'h00) begin fail_cnt++; $display("[TB] FAIL midreset_data: got %h expected 00", rx_data); end
        assert_cnt++; if (rx_busy !== 1'b0) begin fail_cnt++; $display("[TB] FAIL midreset_busy: got %b expected 0", rx_busy); end
        assert_cnt++; if (rx_frame_error !== 1'b0) begin fail_cnt++; $display("[TB] FAIL midreset_fe: got %b expected 0", rx_frame_error); end
        assert_cnt++; if (rx_overrun !== 1'b0) begin fail_cnt++; $display("[TB] FAIL midreset_ov: got %b expected 0", rx_overrun); end
      end
    join
    hold(5);
    r0 = valid_rises;
    assert_cnt++; if (rx_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL midreset_partial_lost: got %b expected 0", rx_valid); end
    send_byte(8'h81, 1'b1, 10, 1'b0);
    hold(5);
    assert_cnt++; if (rx_data !== 8'h81) begin fail_cnt++; $display("[TB] FAIL midreset_next_data: got %h expected 81", rx_data); end
    assert_cnt++; if (valid_rises != r0 + 1) begin fail_cnt++; $display("[TB] FAIL midreset_next_valid: got %0d expected %0d", valid_rises, r0 + 1); end
    assert_cnt++; if (fe_cnt != fe0 || ov_cnt != ov0) begin fail_cnt++; $display("[TB] FAIL midreset_flags: got fe %0d ov %0d expected fe %0d ov %0d", fe_cnt, ov_cnt, fe0, ov0); end
    rx_ready = 1'b1;
    hold(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_ena_gating();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    gate_on = 1'b1;
    fork
      begin
        send_byte(8'hC3, 1'b1, 10, 1'b0);
        gate_on = 1'b0;
      end
      begin
        while (gate_on) begin
          repeat (13) @(negedge clk);
          ena = 1'b0;
          repeat (7) @(negedge clk);
          ena = 1'b1;
        end
      end
    join
    ena = 1'b1;
    @(posedge clk); #1;
    hold(5);
    assert_cnt++; if (rx_data !== 8'hC3) begin fail_cnt++; $display("[TB] FAIL ena_data: got %h expected c3", rx_data); end
    assert_cnt++; if (rx_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL ena_valid: got %b expected 1", rx_valid); end
    assert_cnt++; if (fe_cnt != fe0 || ov_cnt != ov0) begin fail_cnt++; $display("[TB] FAIL ena_flags: got fe %0d ov %0d expected fe %0d ov %0d", fe_cnt, ov_cnt, fe0, ov0); end
    assert_cnt++; if (valid_rise_cyc - last_start_cyc <= 98) begin fail_cnt++; $display("[TB] FAIL ena_stretch: got %0d expected >98", valid_rise_cyc - last_start_cyc); end
    rx_ready = 1'b1;
    hold(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_default_params();
    send_byte(8'h5A, 1'b1, 434, 1'b1);
    hold(5);
    assert_cnt++; if (rx_data_s !== 8'h5A) begin fail_cnt++; $display("[TB] FAIL slow_data: got %h expected 5a", rx_data_s); end
    assert_cnt++; if (rx_valid_s !== 1'b1) begin fail_cnt++; $display("[TB] FAIL slow_valid: got %b expected 1", rx_valid_s); end
    assert_cnt++; if (slow_rise_cyc - last_start_cyc != 4126) begin fail_cnt++; $display("[TB] FAIL slow_latency: got %0d expected 4126", slow_rise_cyc - last_start_cyc); end
    assert_cnt++; if (busy_s !== 1'b0 || fe_s !== 1'b0 || ov_s !== 1'b0) begin fail_cnt++; $display("[TB] FAIL slow_flags: got busy %b fe %b ov %b expected 0 0 0", busy_s, fe_s, ov_s); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_ena_gating();
    test_default_params();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
